tea_cipher: RTL and testbench

Parametrised TEA block cipher core. Encrypts or decrypts one 64-bit block per transaction under a runtime 128-bit key, one full Feistel cycle per clock. Block data and key arrive on a valid/ready input channel; the result leaves on a valid/ready output channel. Sits between the key/data loader and result checker, replacing the fixed-vector, encrypt-only `encrypt` module.

---
 rtl/tea_pkg.sv | 49 ++++
 rtl/tea_round.sv | 48 ++++
 rtl/tea_cipher.sv | 124 ++++++++++++
 tb/tb_tea_cipher.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// tea_pkg: shared types, constants and the TEA mixing function for the
// tea_cipher core and its round sub-module.
//   DELTA_DEFAULT : standard TEA key-schedule constant
//   tea_state_e   : controller states (IDLE, RUN, DONE)
//   tea_key_t     : 128-bit key, k0 in the most significant word
//   tea_block_t   : 64-bit block, v0 in the most significant word
//   tea_f()       : ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb), logical shifts
//   tea_dec_sum() : DELTA*ROUNDS mod 2^32, the starting sum for decryption
package tea_pkg;

  localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tea_state_e;

  typedef struct packed {
    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [31:0] k3;
  } tea_key_t;

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
  } tea_block_t;

  function automatic logic [31:0] tea_f(input logic [31:0] v,
                                        input logic [31:0] sum,
                                        input logic [31:0] ka,
                                        input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

  // Repeated addition keeps the product mod 2^32 without wide intermediates.
  function automatic logic [31:0] tea_dec_sum(input logic [31:0] delta,
                                              input int          rounds);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < rounds; i++) begin
      s = s + delta;
    end
    return s;
  endfunction

endpackage

// File: rtl/tea_round.sv
// tea_round: one full TEA Feistel cycle, purely combinational.
// Ports:
//   mode     in  : 0 = encrypt, 1 = decrypt
//   v0, v1   in  : current block halves
//   sum      in  : current schedule sum
//   key      in  : 128-bit key (k0..k3)
//   v0_next  out : block half v0 after this cycle
//   v1_next  out : block half v1 after this cycle
//   sum_next out : schedule sum after this cycle
module tea_round
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = DELTA_DEFAULT
) (
  input  logic        mode,
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [31:0] sum,
  input  tea_key_t    key,
  output logic [31:0] v0_next,
  output logic [31:0] v1_next,
  output logic [31:0] sum_next
);

  logic [31:0] sum_enc;
  logic [31:0] v0_enc;
  logic [31:0] v1_enc;
  logic [31:0] sum_dec;
  logic [31:0] v0_dec;
  logic [31:0] v1_dec;

  // Encrypt: the sum advances first, and the v1 half-round uses the
  // freshly updated v0 from the same cycle.
  assign sum_enc = sum + DELTA;
  assign v0_enc  = v0 + tea_f(v1, sum_enc, key.k0, key.k1);
  assign v1_enc  = v1 + tea_f(v0_enc, sum_enc, key.k2, key.k3);

  // Decrypt undoes the halves in reverse order with the pre-decrement sum,
  // then steps the sum back.
  assign v1_dec  = v1 - tea_f(v0, sum, key.k2, key.k3);
  assign v0_dec  = v0 - tea_f(v1_dec, sum, key.k0, key.k1);
  assign sum_dec = sum - DELTA;

  assign v0_next  = mode ? v0_dec  : v0_enc;
  assign v1_next  = mode ? v1_dec  : v1_enc;
  assign sum_next = mode ? sum_dec : sum_enc;

endmodule

// File: rtl/tea_cipher.sv
// tea_cipher: iterative TEA encrypt/decrypt core, one Feistel cycle per clock.
// Ports:
//   clk       in  : clock, rising edge
//   reset_n   in  : asynchronous active-low reset
//   in_valid  in  : block, key and mode presented
//   in_ready  out : core idle and able to accept a block
//   mode      in  : 0 = encrypt, 1 = decrypt (sampled on accept)
//   key       in  : 128-bit key, k0 = [127:96] .. k3 = [31:0] (sampled on accept)
//   din       in  : 64-bit block, v0 = [63:32], v1 = [31:0] (sampled on accept)
//   out_valid out : dout holds a finished block
//   out_ready in  : downstream takes dout
//   dout      out : registered result, same word order as din
//   busy      out : high while running or holding a result
module tea_cipher
  import tea_pkg::*;
#(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = DELTA_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [127:0]  key,
  input  logic [63:0]   din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   dout,
  output logic          busy
);

  localparam logic [5:0]  LAST_RND = 6'(ROUNDS - 1);
  localparam logic [31:0] SUM_DEC  = tea_dec_sum(DELTA, ROUNDS);

  tea_state_e  state_q, state_d;
  logic [5:0]  rnd_q, rnd_d;
  tea_block_t  blk_q, blk_d;
  logic [31:0] sum_q, sum_d;
  tea_key_t    key_q, key_d;
  logic        mode_q, mode_d;

  logic [31:0] v0_nx;
  logic [31:0] v1_nx;
  logic [31:0] sum_nx;

  tea_round #(
    .DELTA (DELTA)
  ) u_round (
    .mode     (mode_q),
    .v0       (blk_q.v0),
    .v1       (blk_q.v1),
    .sum      (sum_q),
    .key      (key_q),
    .v0_next  (v0_nx),
    .v1_next  (v1_nx),
    .sum_next (sum_nx)
  );

  // Reset clears the latched block and key as well as control, so an
  // aborted transaction leaves nothing behind on dout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      sum_q   <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      sum_q   <= sum_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    sum_d   = sum_q;
    key_d   = key_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d   = din;
          key_d   = key;
          mode_d  = mode;
          rnd_d   = '0;
          sum_d   = mode ? SUM_DEC : 32'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        blk_d.v0 = v0_nx;
        blk_d.v1 = v1_nx;
        sum_d    = sum_nx;
        rnd_d    = rnd_q + 6'd1;
        if (rnd_q == LAST_RND) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; nothing reaches them from inputs.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign dout      = blk_q;

endmodule

// File: tb/tb_tea_cipher.sv
// tb_tea_cipher: bench for tea_cipher with a 32-round and an 8-round instance.
module tb_tea_cipher;

  logic          clk;
  logic          reset_n;
  logic          iv32;
  logic          iv8;
  logic          mode_i;
  logic [127:0]  key_i;
  logic [63:0]   din_i;
  logic          out_ready;

  logic          rdy32, ov32, busy32;
  logic [63:0]   dout32;
  logic          rdy8, ov8, busy8;
  logic [63:0]   dout8;

  int n_vec  = 0;
  int n_fail = 0;
  logic [63:0] sb[$];

  localparam logic [127:0] K1   = 128'h11111111_22222222_33333333_44444444;
  localparam logic [63:0]  PT1  = 64'h12345678_9ABCDEF0;
  localparam logic [63:0]  CT1  = 64'h5CF85E83_E967E1FD;
  localparam logic [63:0]  CT0  = 64'h41EA3A0A_94BAA940;

  typedef struct {
    logic          m;
    logic [127:0]  k;
    logic [63:0]   d;
    logic [63:0]   e;
  } vec_t;

  vec_t tbl[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tea_cipher #(.ROUNDS(32)) u_dut32 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (iv32),
    .in_ready  (rdy32),
    .mode      (mode_i),
    .key       (key_i),
    .din       (din_i),
    .out_valid (ov32),
    .out_ready (out_ready),
    .dout      (dout32),
    .busy      (busy32)
  );

  tea_cipher #(.ROUNDS(8)) u_dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (iv8),
    .in_ready  (rdy8),
    .mode      (mode_i),
    .key       (key_i),
    .din       (din_i),
    .out_valid (ov8),
    .out_ready (out_ready),
    .dout      (dout8),
    .busy      (busy8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy_of(input bit sel);
    return sel ? rdy8 : rdy32;
  endfunction

  function automatic logic ov_of(input bit sel);
    return sel ? ov8 : ov32;
  endfunction

  function automatic logic [63:0] dout_of(input bit sel);
    return sel ? dout8 : dout32;
  endfunction

  // Reference TEA encryption written straight from the algorithm.
  function automatic logic [63:0] model_enc(input logic [63:0] d, input logic [127:0] k,
                                            input int r);
    logic [31:0] y, z, s;
    y = d[63:32];
    z = d[31:0];
    s = '0;
    for (int i = 0; i < r; i++) begin
      s = s + 32'h9E3779B9;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  // One full transaction on the selected instance with out_ready held high.
  task automatic run_txn(input bit sel, input logic m, input logic [127:0] k,
                         input logic [63:0] d, input logic [63:0] exp, input int lat_exp);
    int cyc;
    logic [63:0] e;
    mode_i    = m;
    key_i     = k;
    din_i     = d;
    out_ready = 1'b1;
    if (sel) iv8 = 1'b1; else iv32 = 1'b1;
    cyc = 0;
    while (!rdy_of(sel) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!rdy_of(sel)) begin
      check("accept_timeout", 64'(rdy_of(sel)), 64'd1);
      iv8 = 1'b0; iv32 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    sb.push_back(exp);
    // Scramble the inputs; the core must be working from its latched copies.
    mode_i = ~m;
    key_i  = {$urandom, $urandom, $urandom, $urandom};
    din_i  = {$urandom, $urandom};
    cyc = 0;
    while (!ov_of(sel) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(sel ? "latency8" : "latency32", 64'(cyc), 64'(lat_exp));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check(sel ? "dout8" : "dout32", dout_of(sel), e);
    end
    @(posedge clk); #1;
    check("release_to_idle", {62'd0, ov_of(sel), rdy_of(sel)}, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  e;
    logic [63:0]  d;
    logic [63:0]  ct;
    logic [127:0] k;
    int           cyc;

    tbl[0] = '{1'b0, K1,     PT1,   CT1};
    tbl[1] = '{1'b1, K1,     CT1,   PT1};
    tbl[2] = '{1'b0, 128'd0, 64'd0, CT0};
    tbl[3] = '{1'b1, 128'd0, CT0,   64'd0};

    reset_n   = 1'b1;
    iv32      = 1'b0;
    iv8       = 1'b0;
    mode_i    = 1'b0;
    key_i     = '0;
    din_i     = '0;
    out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_in_ready",  64'(rdy32),  64'd1);
    check("rst_out_valid", 64'(ov32),   64'd0);
    check("rst_busy",      64'(busy32), 64'd0);
    check("rst_dout",      dout32,      64'd0);
    check("rst8_state",    {60'd0, rdy8, ov8, busy8, 1'b0}, 64'h8);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Known-answer vectors on the 32-round core.
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, tbl[i].m, tbl[i].k, tbl[i].d, tbl[i].e, 32);
    end

    // Backpressure: result held for 10 cycles, new in_valid ignored.
    check("bp_idle", 64'(rdy32), 64'd1);
    mode_i = 1'b0; key_i = K1; din_i = PT1; out_ready = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    sb.push_back(CT1);
    cyc = 0;
    while (!ov32 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_latency", 64'(cyc), 64'd32);
    e = sb.pop_front();
    iv32  = 1'b1;
    din_i = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      check("bp_dout_hold", dout32, e);
      check("bp_in_ready",  64'(rdy32), 64'd0);
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    out_ready = 1'b1;
    check("bp_still_valid", 64'(ov32), 64'd1);
    @(posedge clk); #1;
    check("bp_release", {61'd0, rdy32, ov32, busy32}, 64'h4);

    // Asynchronous abort partway through round 15.
    mode_i = 1'b0; key_i = K1; din_i = PT1; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy32), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_in_ready",  64'(rdy32),  64'd1);
    check("abort_out_valid", 64'(ov32),   64'd0);
    check("abort_busy",      64'(busy32), 64'd0);
    check("abort_dout",      dout32,      64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_txn(1'b0, 1'b0, K1, PT1, CT1, 32);

    // 8-round core: random round trips against the reference model.
    for (int i = 0; i < 100; i++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      d  = {$urandom, $urandom};
      ct = model_enc(d, k, 8);
      run_txn(1'b1, 1'b0, k, d, ct, 8);
      run_txn(1'b1, 1'b1, k, ct, d, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
